// File: rtl/collect_pkg.sv
// Shared types and helpers for the collect switch: FSM states, source encoding,
// and the derivation of the forwarded command width.
package collect_pkg;

    typedef enum logic {
        BUS_PRIO   = 1'b0,
        NODE_FORCE = 1'b1
    } fsm_state_e;

    localparam logic SRC_BUS  = 1'b0;
    localparam logic SRC_NODE = 1'b1;

    // Forwarded mask drops this node's bit, but never collapses below one bit.
    function automatic int unsigned out_cmd_width(input int unsigned in_width);
        return (in_width == 1) ? 1 : in_width - 1;
    endfunction

endpackage

// File: rtl/collect_node_fifo.sv
// Synchronous FIFO buffering local node beats; pointers carry a wrap bit so
// full and empty are told apart without a separate count.
module collect_node_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/collect_2x1_one_hot_seq.sv
// One node of a gather chain: merges upstream bus beats with buffered local
// beats, bus first, with a bounded wait before the node is forced through.
module collect_2x1_one_hot_seq
    import collect_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH        = 32,
    parameter  int unsigned IN_COMMAND_WIDTH  = 2,
    parameter  int unsigned NODE_FIFO_DEPTH   = 2,
    parameter  int unsigned MAX_WAIT          = 4,
    localparam int unsigned OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic [IN_COMMAND_WIDTH-1:0]  i_cmd,
    output logic [OUT_COMMAND_WIDTH-1:0] o_cmd,
    input  logic                         i_bus_valid,
    input  logic [DATA_WIDTH-1:0]        i_bus_data,
    output logic                         o_bus_ready,
    input  logic                         i_node_valid,
    input  logic [DATA_WIDTH-1:0]        i_node_data,
    output logic                         o_node_ready,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data_bus,
    output logic                         o_src,
    input  logic                         i_ready
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    fsm_state_e            state_q;
    fsm_state_e            state_d;
    logic [CW-1:0]         wait_q;
    logic [CW-1:0]         wait_d;
    logic                  load;
    logic                  bus_grant;
    logic                  node_grant;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;

    assign load         = i_en && !rst && (!o_valid || i_ready);
    assign o_node_ready = i_en && !rst && i_cmd[0] && !fifo_full;
    assign fifo_push    = i_node_valid && o_node_ready;
    assign o_bus_ready  = bus_grant;

    collect_node_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NODE_FIFO_DEPTH)
    ) u_node_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (i_node_data),
        .pop       (node_grant),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_PRIO;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Arbitration: the wait counter only tracks bus grants that overtake a waiting node.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        bus_grant  = 1'b0;
        node_grant = 1'b0;
        case (state_q)
            BUS_PRIO: begin
                if (load) begin
                    if (i_bus_valid) begin
                        bus_grant = 1'b1;
                        if (fifo_empty) begin
                            wait_d = '0;
                        end else if (wait_q == CW'(MAX_WAIT - 1)) begin
                            wait_d  = CW'(MAX_WAIT);
                            state_d = NODE_FORCE;
                        end else begin
                            wait_d = wait_q + CW'(1);
                        end
                    end else if (!fifo_empty) begin
                        node_grant = 1'b1;
                        wait_d     = '0;
                    end else begin
                        wait_d = '0;
                    end
                end
            end
            NODE_FORCE: begin
                if (i_en && fifo_empty) begin
                    state_d = BUS_PRIO;
                    wait_d  = '0;
                end else if (load) begin
                    node_grant = 1'b1;
                    state_d    = BUS_PRIO;
                    wait_d     = '0;
                end
            end
            default: begin
                state_d = BUS_PRIO;
                wait_d  = '0;
            end
        endcase
    end

    // Output stage and forwarded command.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_src      <= SRC_BUS;
            o_cmd      <= '0;
        end else begin
            o_cmd <= i_en ? OUT_COMMAND_WIDTH'(i_cmd >> 1) : '0;
            if (load) begin
                o_valid <= bus_grant || node_grant;
                if (bus_grant) begin
                    o_data_bus <= i_bus_data;
                    o_src      <= SRC_BUS;
                end else if (node_grant) begin
                    o_data_bus <= fifo_data;
                    o_src      <= SRC_NODE;
                end
            end
        end
    end

endmodule

// File: tb/tb_collect_2x1_one_hot_seq.sv
// Directed bench for collect_2x1_one_hot_seq: expected beats queue in a scoreboard
// that a negedge monitor drains; ready flags and held outputs are checked inline.
module tb_collect_2x1_one_hot_seq;

    localparam int unsigned DW = 32;

    // Per-cycle expected ready flags, bit c = cycle c of the scenario.
    localparam logic [7:0] BR_STARVE = 8'b1101_1111;
    localparam logic [6:0] BR_BP     = 7'b100_0001;
    localparam logic [6:0] NR_BP     = 7'b000_0011;

    typedef struct packed {
        logic          src;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_en;
    logic [1:0]    i_cmd;
    logic [0:0]    o_cmd;
    logic          i_bus_valid;
    logic [DW-1:0] i_bus_data;
    logic          o_bus_ready;
    logic          i_node_valid;
    logic [DW-1:0] i_node_data;
    logic          o_node_ready;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic          o_src;
    logic          i_ready;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    collect_2x1_one_hot_seq #(
        .DATA_WIDTH       (DW),
        .IN_COMMAND_WIDTH (2),
        .NODE_FIFO_DEPTH  (2),
        .MAX_WAIT         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_cmd        (i_cmd),
        .o_cmd        (o_cmd),
        .i_bus_valid  (i_bus_valid),
        .i_bus_data   (i_bus_data),
        .o_bus_ready  (o_bus_ready),
        .i_node_valid (i_node_valid),
        .i_node_data  (i_node_data),
        .o_node_ready (o_node_ready),
        .o_valid      (o_valid),
        .o_data_bus   (o_data_bus),
        .o_src        (o_src),
        .i_ready      (i_ready)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Scoreboard monitor: every accepted output beat must match the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got src=%0d data=0x%0h, required no beat", o_src, o_data_bus);
            end else begin
                e = exp_q.pop_front();
                check("out_data", o_data_bus, e.data);
                check("out_src", DW'(o_src), DW'(e.src));
            end
        end
    end

    // Drive one cycle (entered at posedge+1), check the ready flags mid-cycle.
    task automatic cyc(input string tag, input logic bv, input logic [DW-1:0] bd,
                       input logic nv, input logic [DW-1:0] nd, input logic rdy,
                       input logic en, input logic [1:0] cmd, input logic ebr,
                       input logic enr, output logic acc_b, output logic acc_n);
        i_bus_valid  = bv;
        i_bus_data   = bd;
        i_node_valid = nv;
        i_node_data  = nd;
        i_ready      = rdy;
        i_en         = en;
        i_cmd        = cmd;
        #3;
        check({tag, "_bus_ready"}, DW'(o_bus_ready), DW'(ebr));
        check({tag, "_node_ready"}, DW'(o_node_ready), DW'(enr));
        acc_b = o_bus_ready;
        acc_n = o_node_ready && nv;
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input logic src, input logic [DW-1:0] data);
        beat_t b;
        b.src  = src;
        b.data = data;
        return b;
    endfunction

    initial begin
        logic ab;
        logic an;
        int   bk;
        int   nk;

        rst          = 1'b1;
        i_en         = 1'b0;
        i_cmd        = 2'b00;
        i_bus_valid  = 1'b0;
        i_bus_data   = '0;
        i_node_valid = 1'b0;
        i_node_data  = '0;
        i_ready      = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with every input active.
        cyc("rst0", 1, 32'h77, 1, 32'h66, 1, 1, 2'b11, 0, 0, ab, an);
        cyc("rst1", 1, 32'h77, 1, 32'h66, 1, 1, 2'b11, 0, 0, ab, an);
        check("rst_valid", DW'(o_valid), 0);
        check("rst_data", o_data_bus, 0);
        check("rst_src", DW'(o_src), 0);
        check("rst_cmd", DW'(o_cmd), 0);
        rst = 1'b0;
        exp_q.push_back(mk(1'b0, 32'hA5));
        cyc("first", 1, 32'hA5, 0, 0, 1, 1, 2'b10, 1, 0, ab, an);
        check("first_valid", DW'(o_valid), 1);
        check("first_data", o_data_bus, 32'hA5);
        check("first_src", DW'(o_src), 0);
        check("first_cmd", DW'(o_cmd), 1);
        cyc("first_idle", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);

        // Node only: output appears two cycles after the push.
        exp_q.push_back(mk(1'b1, 32'h11));
        exp_q.push_back(mk(1'b1, 32'h22));
        cyc("node0", 0, 0, 1, 32'h11, 1, 1, 2'b01, 0, 1, ab, an);
        check("node_lat_valid", DW'(o_valid), 0);
        check("node_cmd", DW'(o_cmd), 0);
        cyc("node1", 0, 0, 1, 32'h22, 1, 1, 2'b01, 0, 1, ab, an);
        check("node_out_valid", DW'(o_valid), 1);
        check("node_out_data", o_data_bus, 32'h11);
        check("node_out_src", DW'(o_src), 1);
        cyc("node2", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);
        check("node_out2_data", o_data_bus, 32'h22);
        cyc("node3", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);
        check("node_drained", DW'(o_valid), 0);

        // Starvation bound: four overtaking bus beats, then the node is forced.
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 32'h100 + DW'(i)));
        exp_q.push_back(mk(1'b1, 32'hBEEF));
        exp_q.push_back(mk(1'b0, 32'h105));
        exp_q.push_back(mk(1'b0, 32'h106));
        bk = 0;
        for (int c = 0; c < 8; c++) begin
            cyc("starve", 1, 32'h100 + DW'(bk), (c == 0), 32'hBEEF, 1, 1, 2'b01, BR_STARVE[c], 1, ab, an);
            if (ab) bk++;
            if (c == 5) begin
                check("starve_force_data", o_data_bus, 32'hBEEF);
                check("starve_force_src", DW'(o_src), 1);
            end
        end
        cyc("starve_idle", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);

        // Backpressure: output held, FIFO fills to two, then drains in order.
        exp_q.push_back(mk(1'b0, 32'h200));
        exp_q.push_back(mk(1'b0, 32'h201));
        exp_q.push_back(mk(1'b1, 32'h300));
        exp_q.push_back(mk(1'b1, 32'h301));
        bk = 0;
        nk = 0;
        for (int c = 0; c < 7; c++) begin
            cyc("bp", 1, 32'h200 + DW'(bk), (c < 6), 32'h300 + DW'(nk), (c >= 6), 1, 2'b01,
                BR_BP[c], NR_BP[c], ab, an);
            if (ab) bk++;
            if (an) nk++;
            if (c <= 4) begin
                check("bp_hold_valid", DW'(o_valid), 1);
                check("bp_hold_data", o_data_bus, 32'h200);
            end
        end
        cyc("bp_drain0", 0, 0, 0, 0, 1, 1, 2'b01, 0, 0, ab, an);
        cyc("bp_drain1", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);
        cyc("bp_drain2", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);

        // Gating: node blocked by the mask, then the whole switch disabled.
        exp_q.push_back(mk(1'b0, 32'h400));
        exp_q.push_back(mk(1'b0, 32'h401));
        cyc("gate0", 1, 32'h400, 1, 32'h55, 1, 1, 2'b10, 1, 0, ab, an);
        cyc("gate1", 1, 32'h401, 1, 32'h55, 1, 1, 2'b10, 1, 0, ab, an);
        check("gate_cmd", DW'(o_cmd), 1);
        cyc("gate2", 1, 32'h402, 1, 32'h55, 0, 1, 2'b10, 0, 0, ab, an);
        cyc("dis", 1, 32'h402, 1, 32'h55, 0, 0, 2'b11, 0, 0, ab, an);
        check("dis_cmd", DW'(o_cmd), 0);
        check("dis_hold_valid", DW'(o_valid), 1);
        check("dis_hold_data", o_data_bus, 32'h401);
        cyc("gate3", 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, ab, an);
        check("gate_drained", DW'(o_valid), 0);

        // Reset mid-stream discards the held beat and the buffered node entry.
        cyc("mid0", 1, 32'h500, 1, 32'h600, 0, 1, 2'b01, 1, 1, ab, an);
        check("mid_pre_valid", DW'(o_valid), 1);
        rst = 1'b1;
        cyc("mid_rst", 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, ab, an);
        check("mid_rst_valid", DW'(o_valid), 0);
        check("mid_rst_data", o_data_bus, 0);
        rst = 1'b0;
        cyc("mid1", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);
        check("mid_empty0", DW'(o_valid), 0);
        cyc("mid2", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);
        check("mid_empty1", DW'(o_valid), 0);
        exp_q.push_back(mk(1'b0, 32'h700));
        cyc("mid3", 1, 32'h700, 0, 0, 1, 1, 2'b01, 1, 1, ab, an);
        check("mid_resume_data", o_data_bus, 32'h700);
        cyc("mid4", 0, 0, 0, 0, 1, 1, 2'b01, 0, 1, ab, an);

        check("scoreboard_left", DW'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
